// File: rtl/mips_pkg.sv
// Shared encodings for the memory-port arbiter: requester/owner tags,
// arbiter FSM states and the default widths of the unified memory path.
package mips_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2,
        OWN_DBG  = 2'd3
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int DEF_AW        = 32;
    localparam int DEF_RAM_AW    = 10;
    localparam int DEF_DW        = 32;
    localparam int DEF_RD_LAT    = 1;
    localparam int DEF_IF_STARVE = 4;

    // Wide enough for read latencies 1..3
    localparam int LAT_W = 2;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational three-way priority select: data > fetch > debug, with an
// override input that lets a starved fetch jump ahead of data.
module arb_prio_sel
    import mips_pkg::*;
(
    input  logic   en_i,
    input  logic   if_first_i,
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  logic   dbg_req_i,
    output logic   if_gnt_o,
    output logic   d_gnt_o,
    output logic   dbg_gnt_o,
    output owner_t winner_o
);

    always_comb begin
        if_gnt_o  = 1'b0;
        d_gnt_o   = 1'b0;
        dbg_gnt_o = 1'b0;
        winner_o  = OWN_NONE;
        if (en_i) begin
            if (if_req_i && (if_first_i || !d_req_i)) begin
                if_gnt_o = 1'b1;
                winner_o = OWN_IF;
            end else if (d_req_i) begin
                d_gnt_o  = 1'b1;
                winner_o = OWN_DATA;
            end else if (dbg_req_i) begin
                // Debug only ever takes a slot no pipeline requester wants
                dbg_gnt_o = 1'b1;
                winner_o  = OWN_DBG;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch, data and debug
// requesters; tracks the single in-flight read and returns it to its owner.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int RAM_AW    = DEF_RAM_AW,
    parameter int DW        = DEF_DW,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int IF_STARVE = DEF_IF_STARVE
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    input  logic              dbg_req,
    input  logic [AW-1:0]     dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DW-1:0]     dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output logic              if_stall,
    output logic              d_stall
);

    localparam int SW = $clog2(IF_STARVE + 1);

    state_t            state_q, state_d;
    owner_t            own_q, own_d;
    owner_t            rv_own_q, rv_own_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    owner_t            winner;
    logic [AW-1:0]     sel_addr;
    logic              addr_unused;

    arb_prio_sel u_sel (
        .en_i       (reset && (state_q == ST_IDLE)),
        .if_first_i (starve_q == SW'(IF_STARVE)),
        .if_req_i   (if_req),
        .d_req_i    (d_req),
        .dbg_req_i  (dbg_req),
        .if_gnt_o   (if_gnt),
        .d_gnt_o    (d_gnt),
        .dbg_gnt_o  (dbg_gnt),
        .winner_o   (winner)
    );

    always_comb begin
        sel_addr = '0;
        case (winner)
            OWN_IF:   sel_addr = if_addr;
            OWN_DATA: sel_addr = d_addr;
            OWN_DBG:  sel_addr = dbg_addr;
            default:  sel_addr = '0;
        endcase
    end

    // Byte-lane bits and bits above the RAM depth are dropped: addresses wrap
    assign ram_addr    = sel_addr[RAM_AW+1:2];
    assign addr_unused = ^{sel_addr[AW-1:RAM_AW+2], sel_addr[1:0]};
    assign ram_en      = (winner != OWN_NONE);
    assign ram_we      = d_gnt && d_we;
    assign ram_wdata   = d_wdata;

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        lat_d    = lat_q;
        rv_own_d = OWN_NONE;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                if (ram_en && !ram_we) begin
                    own_d   = winner;
                    lat_d   = LAT_W'(RD_LAT);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    // RAM data is valid now; the return cycle itself is IDLE
                    state_d  = ST_IDLE;
                    rv_own_d = own_q;
                    rdata_d  = ram_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (if_gnt) begin
            starve_d = '0;
        end else if (if_req && (starve_q != SW'(IF_STARVE))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            own_q    <= OWN_NONE;
            rv_own_q <= OWN_NONE;
            lat_q    <= '0;
            starve_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            rv_own_q <= rv_own_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
        end
    end

    assign if_rvalid  = (rv_own_q == OWN_IF);
    assign d_rvalid   = (rv_own_q == OWN_DATA);
    assign dbg_rvalid = (rv_own_q == OWN_DBG);
    assign if_rdata   = rdata_q;
    assign d_rdata    = rdata_q;
    assign dbg_rdata  = rdata_q;

    assign if_stall = (if_req && !if_gnt) || ((state_q == ST_BUSY) && (own_q == OWN_IF));
    assign d_stall  = (d_req && !d_gnt) || ((state_q == ST_BUSY) && (own_q == OWN_DATA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single-access vectors on a
// one-cycle-latency instance plus hand sequences, one of them on a 3-cycle instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ram_init;
    logic        if_req, d_req, d_we, dbg_req;
    logic [31:0] if_addr, d_addr, d_wdata, dbg_addr;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, dbg_gnt1, dbg_rvalid1;
    logic [31:0] if_rdata1, d_rdata1, dbg_rdata1, ram_wdata1, ram_rdata1;
    logic        ram_en1, ram_we1, if_stall1, d_stall1;
    logic [9:0]  ram_addr1;

    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, dbg_gnt3, dbg_rvalid3;
    logic [31:0] if_rdata3, d_rdata3, dbg_rdata3, ram_wdata3, ram_rdata3;
    logic        ram_en3, ram_we3, if_stall3, d_stall3;
    logic [9:0]  ram_addr3;

    mem_port_arbiter #(.RD_LAT(1)) dut1 (
        .clock(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1),
        .if_stall(if_stall1), .d_stall(d_stall1)
    );

    mem_port_arbiter #(.RD_LAT(3)) dut3 (
        .clock(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3),
        .if_stall(if_stall3), .d_stall(d_stall3)
    );

    // RAM models: word w holds 0x1000_0000 + w until written
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] rd1, s0, s1, s2;
    assign ram_rdata1 = rd1;
    assign ram_rdata3 = s2;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 32'h1000_0000 + 32'(i);
        end else if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
            else         rd1 <= mem1[ram_addr1];
        end
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= 32'h1000_0000 + 32'(i);
        end else if (ram_en3) begin
            if (ram_we3) mem3[ram_addr3] <= ram_wdata3;
            else         s0 <= mem3[ram_addr3];
        end
        s1 <= s0;
        s2 <= s1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        dbg_req = 1'b0;
    endtask

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        br;
        logic [31:0] ba;
        logic [2:0]  gnt;    // {if, d, dbg}
        logic        ren;
        logic        rwe;
        logic [9:0]  raddr;
        logic [1:0]  stall;  // {if, d} in the grant cycle
        logic [1:0]  rv;     // owner of the returned read, 0 = none
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vec_t        v;
        logic [31:0] got;

        //        ifr   ifa           dr    dwe   da          dwd           br    ba        gnt     ren   rwe   raddr    stall  rv    rdata
        vecs[0]  = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 32'h0,  3'b100, 1'b1, 1'b0, 10'h004, 2'b00, 2'd1, 32'h1000_0004};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h20,     32'hDEADBEEF, 1'b0, 32'h0,  3'b010, 1'b1, 1'b1, 10'h008, 2'b00, 2'd0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h20,     32'h0,        1'b0, 32'h0,  3'b010, 1'b1, 1'b0, 10'h008, 2'b00, 2'd2, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 32'h0C, 3'b001, 1'b1, 1'b0, 10'h003, 2'b00, 2'd3, 32'h1000_0003};
        vecs[4]  = '{1'b1, 32'h100,      1'b1, 1'b0, 32'h44,     32'h0,        1'b1, 32'h08, 3'b010, 1'b1, 1'b0, 10'h011, 2'b10, 2'd2, 32'h1000_0011};
        vecs[5]  = '{1'b1, 32'h104,      1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 32'h08, 3'b100, 1'b1, 1'b0, 10'h041, 2'b00, 2'd1, 32'h1000_0041};
        vecs[6]  = '{1'b1, 32'h200,      1'b1, 1'b1, 32'h30,     32'h12345678, 1'b0, 32'h0,  3'b010, 1'b1, 1'b1, 10'h00C, 2'b10, 2'd0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h1003,   32'h0,        1'b0, 32'h0,  3'b010, 1'b1, 1'b0, 10'h000, 2'b00, 2'd2, 32'h1000_0000};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h30,     32'h0,        1'b0, 32'h0,  3'b010, 1'b1, 1'b0, 10'h00C, 2'b00, 2'd2, 32'h12345678};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 32'h0,  3'b000, 1'b0, 1'b0, 10'h000, 2'b00, 2'd0, 32'h0};
        vecs[10] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 32'h0,  3'b100, 1'b1, 1'b0, 10'h3FF, 2'b00, 2'd1, 32'h1000_03FF};

        // Reset held three cycles with every requester active
        reset = 1'b0; ram_init = 1'b1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; dbg_req = 1'b1;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h0; dbg_addr = 32'h0C;
        for (int c = 0; c < 3; c++) begin
            tick();
            #3;
            chk("rst_gnt", 32'({if_gnt1, d_gnt1, dbg_gnt1}), 32'h0);
            chk("rst_rvalid", 32'({if_rvalid1, d_rvalid1, dbg_rvalid1}), 32'h0);
            chk("rst_ram", 32'({ram_en1, ram_we1}), 32'h0);
            chk("rst_rdata", if_rdata1, 32'h0);
            chk("rst_stall", 32'({if_stall1, d_stall1}), 32'h3);
            $display("reset cycle %0d checked", c);
        end
        reset = 1'b1; ram_init = 1'b0;
        #3;
        chk("rel_gnt", 32'({if_gnt1, d_gnt1, dbg_gnt1}), 32'h2);
        tick();
        idle_reqs();
        for (int c = 0; c < 6; c++) tick();

        // Table of single accesses, each followed by two idle cycles
        for (int k = 0; k < 11; k++) begin
            v = vecs[k];
            if_req = v.ifr; if_addr = v.ifa;
            d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
            dbg_req = v.br; dbg_addr = v.ba;
            #3;
            chk("vec_gnt", 32'({if_gnt1, d_gnt1, dbg_gnt1}), 32'(v.gnt));
            chk("vec_ram_en", 32'(ram_en1), 32'(v.ren));
            chk("vec_ram_we", 32'(ram_we1), 32'(v.rwe));
            if (v.ren) chk("vec_ram_addr", 32'(ram_addr1), 32'(v.raddr));
            if (v.rwe) chk("vec_ram_wdata", ram_wdata1, v.dwd);
            chk("vec_stall", 32'({if_stall1, d_stall1}), 32'(v.stall));
            tick();
            idle_reqs();
            #3;
            chk("vec_rv_early", 32'({if_rvalid1, d_rvalid1, dbg_rvalid1}), 32'h0);
            chk("vec_inflight", 32'({if_stall1, d_stall1}), 32'({v.rv == 2'd1, v.rv == 2'd2}));
            tick();
            #3;
            chk("vec_rvalid", 32'({if_rvalid1, d_rvalid1, dbg_rvalid1}),
                32'({v.rv == 2'd1, v.rv == 2'd2, v.rv == 2'd3}));
            case (v.rv)
                2'd1:    got = if_rdata1;
                2'd2:    got = d_rdata1;
                2'd3:    got = dbg_rdata1;
                default: got = 32'h0;
            endcase
            if (v.rv != 2'd0) chk("vec_rdata", got, v.rdata);
            $display("vector %0d: gnt=%b raddr=0x%0h rv=%0d rdata=0x%0h", k, v.gnt, v.raddr, v.rv, got);
            tick();
        end

        // Starvation: data writes every cycle, fetch wins after four denials
        idle_reqs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; if_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            d_wdata = 32'hA000_0000 + 32'(c);
            if_req  = (c <= 4);
            #3;
            chk("starve_d_gnt", 32'(d_gnt1), 32'(c < 4 || c > 5));
            chk("starve_if_gnt", 32'(if_gnt1), 32'(c == 4));
            chk("starve_if_stall", 32'(if_stall1), 32'(c < 4 || c == 5));
            chk("starve_if_rvalid", 32'(if_rvalid1), 32'(c == 6));
            if (c == 6) chk("starve_if_rdata", if_rdata1, 32'h1000_0004);
            $display("starve cycle %0d: if_gnt=%b d_gnt=%b", c, if_gnt1, d_gnt1);
            tick();
        end
        idle_reqs();
        for (int c = 0; c < 6; c++) tick();

        // Debug waits for the first idle cycle with no pipeline request
        begin
            logic [6:0] s_d, s_if, s_dbg, e_d, e_if, e_dbg;
            s_d = 7'b0001101; s_if = 7'b0000011; s_dbg = 7'b0011111;
            e_d = 7'b0001001; e_if = 7'b0000010; e_dbg = 7'b0010000;
            d_addr = 32'h50; d_wdata = 32'h5555_AAAA; d_we = 1'b1;
            if_addr = 32'h18; dbg_addr = 32'h0C;
            for (int c = 0; c < 7; c++) begin
                d_req = s_d[c]; if_req = s_if[c]; dbg_req = s_dbg[c];
                #3;
                chk("dbg_seq_gnt", 32'({if_gnt1, d_gnt1, dbg_gnt1}), 32'({e_if[c], e_d[c], e_dbg[c]}));
                if (c == 4) chk("dbg_seq_addr", 32'(ram_addr1), 32'h3);
                if (c == 3) chk("dbg_seq_if_rdata", if_rdata1, 32'h1000_0006);
                chk("dbg_seq_rvalid", 32'({if_rvalid1, dbg_rvalid1}), 32'({c == 3, c == 6}));
                if (c == 6) chk("dbg_seq_rdata", dbg_rdata1, 32'h1000_0003);
                $display("debug cycle %0d: gnt=%b%b%b", c, if_gnt1, d_gnt1, dbg_gnt1);
                tick();
            end
        end
        idle_reqs();
        for (int c = 0; c < 6; c++) tick();

        // Reset one cycle after a 3-cycle read grant drops that read
        if_req = 1'b1; if_addr = 32'h10;
        #3;
        chk("mid_gnt", 32'(if_gnt3), 32'h1);
        tick();
        idle_reqs();
        reset = 1'b0;
        #3;
        chk("mid_inflight", 32'(if_stall3), 32'h1);
        tick();
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h14;
        #3;
        chk("post_rst_gnt", 32'(if_gnt3), 32'h1);
        tick();
        idle_reqs();
        for (int c = 1; c <= 4; c++) begin
            #3;
            chk("lat3_rvalid", 32'({if_rvalid3, d_rvalid3, dbg_rvalid3}), 32'({c == 4, 1'b0, 1'b0}));
            if (c == 4) chk("lat3_rdata", if_rdata3, 32'h1000_0005);
            $display("lat3 cycle %0d: if_rvalid=%b if_rdata=0x%0h", c, if_rvalid3, if_rdata3);
            tick();
        end
        #3;
        chk("lat3_after", 32'({if_rvalid3, if_stall3}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
